// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port data RAM between instruction fetch
// (requester 0) and load/store (requester 1). One access is issued per cycle,
// load/store wins ties unless fetch has waited STARVE_LIMIT cycles, and read
// responses (or error responses for illegal/misaligned accesses) come back
// exactly one cycle after the grant, sign-extended per the RISC-V funct3.
module spram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [31:0]           m0_addr,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [2:0]            m0_rwtyp,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic [31:0]           m1_addr,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [2:0]            m1_rwtyp,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [2:0]            ram_rwtyp,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt;
    logic                  grant0;
    logic                  grant1;
    logic                  any_gnt;
    logic [31:0]           sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_typ;
    logic                  sel_ok;

    logic                  pend_valid;
    logic                  pend_id;
    logic [2:0]            pend_typ;
    logic                  pend_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  unused_addr;

    // Legal accesses: B/H/W for reads and writes, BU/HU for reads only,
    // with halfwords on even and words on 4-byte boundaries.
    function automatic logic access_ok(input logic [1:0] lsb, input logic we,
                                       input logic [2:0] typ);
        logic ok;
        ok = 1'b1;
        if (typ[1:0] == 2'b11) ok = 1'b0;
        if (typ[2:1] == 2'b11) ok = 1'b0;
        if (we && typ[2]) ok = 1'b0;
        if (typ[1:0] == 2'b01 && lsb[0]) ok = 1'b0;
        if (typ == 3'b010 && lsb != 2'b00) ok = 1'b0;
        return ok;
    endfunction

    // Fixed priority to load/store, overridden once fetch has starved; reset
    // blocks every grant so nothing reaches the RAM while rst is high.
    always_comb begin
        grant1 = 1'b0;
        grant0 = 1'b0;
        if (!rst) begin
            grant1 = m1_req && !(m0_req && starve_cnt == LIMIT);
            grant0 = m0_req && !grant1;
        end
    end

    assign m0_gnt  = grant0;
    assign m1_gnt  = grant1;
    assign any_gnt = grant0 | grant1;

    // Route the winning requester's access fields toward the RAM.
    always_comb begin
        sel_addr  = m0_addr;
        sel_we    = m0_we;
        sel_wdata = m0_wdata;
        sel_typ   = m0_rwtyp;
        if (grant1) begin
            sel_addr  = m1_addr;
            sel_we    = m1_we;
            sel_wdata = m1_wdata;
            sel_typ   = m1_rwtyp;
        end
    end

    assign sel_ok = access_ok(sel_addr[1:0], sel_we, sel_typ);

    // Drive the RAM only on a grant; strobes are suppressed for bad accesses.
    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_rwtyp   = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        if (any_gnt) begin
            ram_address = sel_addr[ADDR_WIDTH+1:2];
            ram_data    = sel_wdata;
            ram_rwtyp   = sel_typ;
            ram_rden    = sel_ok && !sel_we;
            ram_wren    = sel_ok && sel_we;
        end
    end

    // Upper address bits wrap within the RAM and are intentionally dropped.
    assign unused_addr = ^sel_addr[31:ADDR_WIDTH+2];

    // Count how long fetch has waited behind load/store, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (m0_req && grant1) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Remember who is owed a response next cycle; legal writes owe nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
            pend_typ   <= 3'b000;
            pend_err   <= 1'b0;
        end else begin
            pend_valid <= any_gnt && (!sel_ok || !sel_we);
            pend_id    <= grant1;
            pend_typ   <= sel_typ;
            pend_err   <= !sel_ok;
        end
    end

    // Shape the RAM word per the latched access type; errors return zero.
    always_comb begin
        resp_data = ram_q;
        case (pend_typ)
            3'b000:  resp_data = {{24{ram_q[7]}}, ram_q[7:0]};
            3'b001:  resp_data = {{16{ram_q[15]}}, ram_q[15:0]};
            default: resp_data = ram_q;
        endcase
        if (pend_err) resp_data = '0;
    end

    assign m0_rvalid = pend_valid && !pend_id;
    assign m1_rvalid = pend_valid && pend_id;
    assign m0_err    = m0_rvalid && pend_err;
    assign m1_err    = m1_rvalid && pend_err;
    assign m0_rdata  = m0_rvalid ? resp_data : '0;
    assign m1_rdata  = m1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed sequence against spram_arbiter with a behavioural
// RAM, an arbitration/legality model and a response scoreboard.
module tb_spram_arbiter;

    localparam int AW     = 16;
    localparam int STARVE = 4;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [2:0]  m0_rwtyp;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [2:0]  m1_rwtyp;
    logic [AW-1:0] ram_address;
    logic        ram_rden, ram_wren;
    logic [31:0] ram_data, ram_q;
    logic [2:0]  ram_rwtyp;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    int          test_cnt = 0;
    int          fail_cnt = 0;
    int          model_starve = 0;
    logic [31:0] ram [0:65535];
    logic [31:0] model_mem [0:65535];

    spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_rwtyp(m0_rwtyp), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_rwtyp(m1_rwtyp), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_address(ram_address), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_data(ram_data), .ram_rwtyp(ram_rwtyp), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: lane-less byte/half/word writes, zero-extended registered reads.
    always @(posedge clk) begin
        if (ram_wren) begin
            case (ram_rwtyp)
                3'b000:  ram[ram_address][7:0]  <= ram_data[7:0];
                3'b001:  ram[ram_address][15:0] <= ram_data[15:0];
                default: ram[ram_address]       <= ram_data;
            endcase
        end
        if (ram_rden) begin
            case (ram_rwtyp)
                3'b000, 3'b100: ram_q <= {24'b0, ram[ram_address][7:0]};
                3'b001, 3'b101: ram_q <= {16'b0, ram[ram_address][15:0]};
                default:        ram_q <= ram[ram_address];
            endcase
        end
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic legalModel(input logic [31:0] a, input logic we, input logic [2:0] t);
        case (t)
            3'b000:  return 1'b1;
            3'b001:  return !a[0];
            3'b010:  return a[1:0] == 2'b00;
            3'b100:  return !we;
            3'b101:  return !we && !a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extendModel(input logic [2:0] t, input logic [31:0] w);
        case (t)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Compare the response (if any) that is due in the current cycle.
    task automatic checkOutput();
        resp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare("rvalid_owner", e.id ? m1_rvalid : m0_rvalid, 32'd1);
            compare("rvalid_other", e.id ? m0_rvalid : m1_rvalid, 32'd0);
            compare("rdata", e.id ? m1_rdata : m0_rdata, e.data);
            compare("err", e.id ? m1_err : m0_err, {31'b0, e.err});
        end else begin
            compare("no_rvalid0", m0_rvalid, 32'd0);
            compare("no_rvalid1", m1_rvalid, 32'd0);
        end
    endtask

    // Drive one cycle of requests, check grant/RAM side, then the next response.
    task automatic applyStimulus(
        input logic r0, input logic [31:0] a0, input logic we0, input logic [31:0] wd0, input logic [2:0] t0,
        input logic r1, input logic [31:0] a1, input logic we1, input logic [31:0] wd1, input logic [2:0] t1);
        logic        g0, g1, swe, ok;
        logic [31:0] sa, swd;
        logic [2:0]  st;
        logic [AW-1:0] idx;
        resp_t       e;
        m0_req = r0; m0_addr = a0; m0_we = we0; m0_wdata = wd0; m0_rwtyp = t0;
        m1_req = r1; m1_addr = a1; m1_we = we1; m1_wdata = wd1; m1_rwtyp = t1;
        #2;
        g1 = r1 && !(r0 && model_starve == STARVE);
        g0 = r0 && !g1;
        compare("gnt0", m0_gnt, {31'b0, g0});
        compare("gnt1", m1_gnt, {31'b0, g1});
        if (g0 || g1) begin
            sa  = g1 ? a1 : a0;
            swe = g1 ? we1 : we0;
            swd = g1 ? wd1 : wd0;
            st  = g1 ? t1 : t0;
            idx = sa[AW+1:2];
            ok  = legalModel(sa, swe, st);
            compare("ram_rden", ram_rden, {31'b0, ok && !swe});
            compare("ram_wren", ram_wren, {31'b0, ok && swe});
            if (ok) compare("ram_address", {16'b0, ram_address}, {16'b0, idx});
            if (ok && swe) begin
                compare("ram_data", ram_data, swd);
                case (st)
                    3'b000:  model_mem[idx][7:0]  = swd[7:0];
                    3'b001:  model_mem[idx][15:0] = swd[15:0];
                    default: model_mem[idx]       = swd;
                endcase
            end else begin
                e.id   = g1;
                e.err  = !ok;
                e.data = ok ? extendModel(st, model_mem[idx]) : 32'h0;
                sb.push_back(e);
            end
        end else begin
            compare("idle_rden", ram_rden, 32'd0);
            compare("idle_wren", ram_wren, 32'd0);
        end
        if (r0 && g1) model_starve = (model_starve < STARVE) ? model_starve + 1 : STARVE;
        else model_starve = 0;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        compare({tag, "_gnt0"}, m0_gnt, 32'd0);
        compare({tag, "_gnt1"}, m1_gnt, 32'd0);
        compare({tag, "_rvalid0"}, m0_rvalid, 32'd0);
        compare({tag, "_rvalid1"}, m1_rvalid, 32'd0);
        compare({tag, "_rdata0"}, m0_rdata, 32'd0);
        compare({tag, "_rdata1"}, m1_rdata, 32'd0);
        compare({tag, "_err"}, {30'b0, m0_err, m1_err}, 32'd0);
        compare({tag, "_strobes"}, {30'b0, ram_rden, ram_wren}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0; m0_wdata = '0; m0_rwtyp = 3'b010;
        m1_req = 1'b1; m1_addr = 32'h40; m1_we = 1'b0; m1_wdata = '0; m1_rwtyp = 3'b010;
        #2;
        checkAllZero("reset");
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload words through the load/store port.
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h10, 1, 32'hDEADBEEF, 3'b010);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h20, 1, 32'h12345680, 3'b010);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h24, 1, 32'h00008001, 3'b010);

        // Fetch word read, then back-to-back signed/unsigned byte loads.
        applyStimulus(1, 32'h10, 0, 0, 3'b010, 0, 0, 0, 0, 3'b000);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h20, 0, 0, 3'b000);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h20, 0, 0, 3'b100);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h24, 0, 0, 3'b001);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h24, 0, 0, 3'b101);

        // Illegal and misaligned accesses from both requesters.
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h3, 1, 32'h5555, 3'b001);
        applyStimulus(1, 32'h2, 0, 0, 3'b010, 0, 0, 0, 0, 3'b000);
        applyStimulus(1, 32'h10, 0, 0, 3'b011, 0, 0, 0, 0, 3'b000);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h10, 0, 0, 3'b110);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h10, 1, 32'h77, 3'b100);

        // Write then immediate read-back; byte write merge.
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h40, 1, 32'h12345678, 3'b010);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h40, 0, 0, 3'b010);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h44, 1, 32'h11223344, 3'b010);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h44, 1, 32'h000000AA, 3'b000);
        applyStimulus(0, 0, 0, 0, 3'b000, 1, 32'h44, 0, 0, 3'b010);

        // Both requesting continuously: fetch forced through every fifth cycle.
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 32'h10, 0, 0, 3'b010, 1, 32'h40, 0, 0, 3'b010);

        // Address bits above the RAM range wrap; idle cycle issues nothing.
        applyStimulus(1, 32'h0004_0010, 0, 0, 3'b010, 0, 0, 0, 0, 3'b000);
        applyStimulus(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b000);

        // Reset one cycle after a read grant drops the response.
        m0_req = 1'b1; m0_addr = 32'h40; m0_we = 1'b0; m0_rwtyp = 3'b010;
        m1_req = 1'b0;
        #2;
        compare("pre_reset_gnt0", m0_gnt, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m1_req = 1'b1;
        #1;
        checkAllZero("in_reset");
        model_starve = 0;
        @(posedge clk);
        #1;
        checkAllZero("held_reset");
        m0_req = 1'b0; m1_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare("post_reset_rvalid0", m0_rvalid, 32'd0);
        compare("post_reset_rvalid1", m1_rvalid, 32'd0);

        // RAM contents survive the arbiter reset.
        applyStimulus(1, 32'h40, 0, 0, 3'b010, 0, 0, 0, 0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data RAM (byte/half/word access via rwtyp).
- Requester 0 is instruction fetch; requester 1 is load/store.
- Issues at most one RAM access per cycle, with fixed priority to requester 1 and a starvation guard for requester 0.
- Returns read data one cycle after grant, sign-extended per RISC-V funct3, and flags illegal or misaligned accesses.

Parameters:
ADDR_WIDTH, 16, RAM word-address width; RAM index = mN_addr[ADDR_WIDTH+1:2]
DATA_WIDTH, 32, data width; fixed at 32
STARVE_LIMIT, 4, consecutive cycles requester 0 may wait while 1 is granted before 0 is forced through

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m0_req  in  1  requester 0 access request, held until granted
m0_addr  in  32  byte address
m0_we  in  1  1 = write, 0 = read
m0_wdata  in  32  write data, right-aligned
m0_rwtyp  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
m0_gnt  out  1  access accepted this cycle
m0_rvalid  out  1  read data / error valid
m0_rdata  out  32  read data
m0_err  out  1  illegal or misaligned, valid with m0_rvalid
m1_req, m1_addr, m1_we, m1_wdata, m1_rwtyp, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as requester 0
ram_address  out  ADDR_WIDTH  RAM word index
ram_rden  out  1  RAM read strobe
ram_wren  out  1  RAM write strobe
ram_data  out  32  RAM write data
ram_rwtyp  out  3  RAM access type
ram_q  in  32  RAM registered read data (zero-extended), valid cycle after rden

Behaviour:
- Reset (rst=1, async): all gnt/rvalid/err/ram_rden/ram_wren = 0; rdata = 0; starvation counter = 0; pending-response register cleared.
- Reset mid-operation: any in-flight read response is dropped, with no rvalid after reset release.
- Arbitration, combinational in cycle T:
  - Only m1_req: grant 1. Only m0_req: grant 0.
  - Both: grant 1, unless starve_cnt == STARVE_LIMIT, then grant 0.
- Exactly one gnt per cycle at most.
- Starvation counter:
  - Increments when m0_req=1 and 1 is granted.
  - Clears when 0 is granted or m0_req=0.
  - Saturates at STARVE_LIMIT.
- Grant cycle T, RAM side: ram_address = addr[ADDR_WIDTH+1:2]; ram_rwtyp = rwtyp; ram_data = wdata.
- Grant cycle T, strobes: ram_wren = we, ram_rden = ~we, both only if the access is legal.
- Legality:
  - rwtyp[1:0]==11 is illegal.
  - rwtyp 110 or 111 is illegal.
  - Write with rwtyp[2]=1 is illegal.
  - H/HU with addr[0]=1 is misaligned; W with addr[1:0]!=0 is misaligned.
- Illegal or misaligned access: still granted, no RAM strobe, mN_rvalid=1 with mN_err=1 at T+1, rdata=0. This applies to reads and writes.
- Legal read: mN_rvalid=1 at T+1; rdata from ram_q per the type latched at T:
  - B: sign-extend [7:0].
  - H: sign-extend [15:0].
  - BU/HU: ram_q as-is.
  - W: ram_q.
- Legal write: complete at gnt; no rvalid.
- Pipelining: back-to-back grants allowed every cycle, to either requester. The pending register holds id, type and err of the cycle-T access only, so responses stay in issue order and are never merged.
- Requester obligation: hold addr/we/wdata/rwtyp stable while req=1 and gnt=0. A dropped req without gnt is legal; nothing is issued.
- Address bits above ADDR_WIDTH+1 are ignored; the address wraps within the RAM.

Test Plan:
- m0 read W at 0x10 where RAM word 4 = 0xDEADBEEF → m0_gnt at T, ram_rden=1, ram_address=4; m0_rvalid at T+1 with rdata 0xDEADBEEF, err=0.
- m1 LB and LBU at 0x20 where RAM low byte is 0x80 → LB returns 0xFFFFFF80, LBU returns 0x00000080, each one cycle after its grant, back-to-back.
- m0_req and m1_req held high continuously with STARVE_LIMIT=4 → grants 1,1,1,1 then 0, and the pattern repeats; never two gnt in one cycle.
- m1 write SH at 0x3 → gnt, ram_wren=0, m1_rvalid and m1_err at T+1, rdata=0. m0 LW at 0x2 → same error response.
- m1 write SW 0x12345678 at 0x40, then m1 LW 0x40 next cycle → read returns 0x12345678.
- Grant a read at T, assert rst during T+1 → no rvalid during or after reset; all outputs 0 while rst=1.
